fifo_sync: RTL

Single-clock, parametrised successor to our dual-clock byte FIFO: a DEPTH×DATA buffer with extended pointers, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between same-clock producer/consumer stages wherever we need rate smoothing without a CDC. A compile-time option switches the read port from registered (standard) to first-word-fall-through.

---
 rtl/fifo_sync.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock DEPTH x DATA FIFO with extended (wrap-bit) pointers,
// occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
// Compile-time option: define FIFO_SYNC_FWFT_EN for a first-word-fall-through
// read port; left undefined, read_data is registered and updates one cycle
// after an accepted read.
module fifo_sync #(
    parameter int DATA     = 8,
    parameter int DEPTH    = 16,
    parameter int PTR      = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [DATA-1:0] write_data,
    input  logic            rd_en,
    output logic [DATA-1:0] read_data,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [PTR:0]    count,
    output logic            overflow,
    output logic            underflow,
    input  logic            clr_err
);

    localparam logic [PTR:0] LP_ONE = (PTR+1)'(1);
    localparam logic [PTR:0] LP_AF  = (PTR+1)'(AF_LEVEL);
    localparam logic [PTR:0] LP_AE  = (PTR+1)'(AE_LEVEL);

    logic [DATA-1:0] r_mem [DEPTH];
    logic [PTR:0]    r_wr_ptr;
    logic [PTR:0]    r_rd_ptr;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_full;
    logic            w_empty;
    logic [PTR:0]    w_count;
    logic            w_wr_acc;
    logic            w_rd_acc;

    // Flags derive only from the registered pointers, so no request input
    // reaches an output combinationally.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR] != r_rd_ptr[PTR]) &&
                      (r_wr_ptr[PTR-1:0] == r_rd_ptr[PTR-1:0]);
    assign w_count  = r_wr_ptr - r_rd_ptr;

    // Acceptance uses pre-edge flags: full blocks the write of a
    // simultaneous pair, empty blocks the read.
    assign w_wr_acc = wr_en && !w_full && !rst;
    assign w_rd_acc = rd_en && !w_empty && !rst;

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= LP_AF);
    assign almost_empty = (w_count <= LP_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[PTR-1:0]] <= write_data;
        end
    end

    // Pointer update; reset drops all contents in a single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + LP_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + LP_ONE;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head word is presented directly; forced to zero while empty so the
    // port has a defined value after reset.
    assign read_data = w_empty ? '0 : r_mem[r_rd_ptr[PTR-1:0]];
`else
    logic [DATA-1:0] r_rd_data;

    // Registered read port: loads the head word on an accepted read and
    // holds otherwise, including on rejected reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (w_rd_acc) begin
            r_rd_data <= r_mem[r_rd_ptr[PTR-1:0]];
        end
    end

    assign read_data = r_rd_data;
`endif

endmodule
